crtc_mode_loader: RTL and testbench

- Sequences register programming of the MC6845 CRTC from a mode table: on request, writes R0..R(NUM_REGS-1) for the selected display mode as address-write/data-write pairs.
- Sits between the CPU bus and the CRTC bus port. Passes CPU accesses through when idle, stalls them while loading, and holds the CRTC in reset for the duration of a load.

---
 rtl/crtc_mode_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_crtc_mode_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/crtc_mode_loader.sv
// crtc_mode_loader
//
// Programs an MC6845 CRTC from a mode table. On an accepted start, the
// registers R0..R(NUM_REGS-1) of the selected mode are written to the CRTC as
// an address-register write (RS=0, data=register number) followed by a
// data-register write (RS=1, data=table value). While idle, CPU accesses are
// forwarded to the CRTC one en-cycle later. While loading, CPU accesses are
// stalled through cpu_ready and the CRTC is held in reset.
//
// Build option:
//   CRTC_LOADER_CURSOR_PRESERVE_EN  when defined, R14/R15 (cursor address) are
//                                   never fetched or written, so a cursor
//                                   position set by software survives a mode
//                                   change.
//
// Parameters:
//   NUM_REGS  registers written per load, 1..16
//   MODE_W    mode index width
//
// Ports:
//   clk, RESET         clock, asynchronous active-high reset
//   en                 clock enable; nothing advances on edges with en=0
//   start, mode        load request and mode index (mode latched on accept)
//   busy, done         load in progress / one en-cycle completion pulse
//   tbl_adr, tbl_data  mode table address {mode, reg_idx} and its read data
//   cpu_nCS/RnW/RS/data, cpu_ready   CPU side of the CRTC bus
//   crtc_nCS/RnW/RS/data, crtc_data_oe, crtc_nRESET   CRTC side of the bus
//
// Timing: every output is a register. Each register costs three en-cycles
// (FETCH, WADR, WDAT); tbl_data must be valid one en-cycle after tbl_adr
// changes, which is when WADR samples it.

module crtc_mode_loader #(
  parameter int NUM_REGS = 16,
  parameter int MODE_W   = 3
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              en,
  input  logic              start,
  input  logic [MODE_W-1:0] mode,
  output logic              busy,
  output logic              done,
  output logic [MODE_W+3:0] tbl_adr,
  input  logic [7:0]        tbl_data,
  input  logic              cpu_nCS,
  input  logic              cpu_RnW,
  input  logic              cpu_RS,
  input  logic [7:0]        cpu_data,
  output logic              cpu_ready,
  output logic              crtc_nCS,
  output logic              crtc_RnW,
  output logic              crtc_RS,
  output logic [7:0]        crtc_data,
  output logic              crtc_data_oe,
  output logic              crtc_nRESET
);

  // Index of the last register written in a load.
`ifdef CRTC_LOADER_CURSOR_PRESERVE_EN
  localparam int LAST_INT = (NUM_REGS > 14) ? 13 : NUM_REGS - 1;
`else
  localparam int LAST_INT = NUM_REGS - 1;
`endif
  localparam logic [3:0] LAST_IDX = 4'(LAST_INT);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WADR,
    WDAT,
    DONE
  } state_t;

  state_t              state_reg,  state_next;
  logic [3:0]          idx_reg,    idx_next;
  logic [MODE_W-1:0]   mode_reg,   mode_next;
  logic [7:0]          hold_reg,   hold_next;
  logic [MODE_W+3:0]   adr_reg,    adr_next;
  logic                busy_reg,   busy_next;
  logic                done_reg,   done_next;
  logic                ncs_reg,    ncs_next;
  logic                rnw_reg,    rnw_next;
  logic                rs_reg,     rs_next;
  logic [7:0]          data_reg,   data_next;
  logic                oe_reg,     oe_next;
  logic                nreset_reg, nreset_next;

  // State register. Everything advances only on enabled edges.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_reg  <= IDLE;
      idx_reg    <= 4'd0;
      mode_reg   <= '0;
      hold_reg   <= 8'h00;
      adr_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      ncs_reg    <= 1'b1;
      rnw_reg    <= 1'b1;
      rs_reg     <= 1'b0;
      data_reg   <= 8'h00;
      oe_reg     <= 1'b0;
      nreset_reg <= 1'b0;
    end else if (en) begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      mode_reg   <= mode_next;
      hold_reg   <= hold_next;
      adr_reg    <= adr_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      ncs_reg    <= ncs_next;
      rnw_reg    <= rnw_next;
      rs_reg     <= rs_next;
      data_reg   <= data_next;
      oe_reg     <= oe_next;
      nreset_reg <= nreset_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    mode_next   = mode_reg;
    hold_next   = hold_reg;
    adr_next    = adr_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    ncs_next    = ncs_reg;
    rnw_next    = rnw_reg;
    rs_next     = rs_reg;
    data_next   = data_reg;
    oe_next     = oe_reg;
    nreset_next = nreset_reg;

    case (state_reg)
      IDLE: begin
        // Releases the CRTC from reset on the first enabled edge after
        // RESET, and keeps it released while idle.
        nreset_next = 1'b1;
        ncs_next    = cpu_nCS;
        rnw_next    = cpu_RnW;
        rs_next     = cpu_RS;
        data_next   = cpu_data;
        oe_next     = ~cpu_nCS & ~cpu_RnW;
        if (start) begin
          // Any CPU access sampled on this edge is dropped in favour of the
          // load; the bus is parked deselected.
          mode_next   = mode;
          idx_next    = 4'd0;
          busy_next   = 1'b1;
          nreset_next = 1'b0;
          ncs_next    = 1'b1;
          rnw_next    = 1'b1;
          rs_next     = 1'b0;
          oe_next     = 1'b0;
          state_next  = FETCH;
        end
      end

      FETCH: begin
        adr_next   = {mode_reg, idx_reg};
        ncs_next   = 1'b1;
        rnw_next   = 1'b1;
        rs_next    = 1'b0;
        oe_next    = 1'b0;
        state_next = WADR;
      end

      WADR: begin
        // Table data for the address issued in FETCH is valid now; hold it
        // for the data-register write in WDAT.
        hold_next  = tbl_data;
        ncs_next   = 1'b0;
        rnw_next   = 1'b0;
        rs_next    = 1'b0;
        data_next  = {4'b0000, idx_reg};
        oe_next    = 1'b1;
        state_next = WDAT;
      end

      WDAT: begin
        ncs_next  = 1'b0;
        rnw_next  = 1'b0;
        rs_next   = 1'b1;
        data_next = hold_reg;
        oe_next   = 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + 4'd1;
          state_next = FETCH;
        end
      end

      DONE: begin
        done_next   = 1'b1;
        busy_next   = 1'b0;
        ncs_next    = 1'b1;
        rnw_next    = 1'b1;
        rs_next     = 1'b0;
        oe_next     = 1'b0;
        nreset_next = 1'b1;
        state_next  = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign tbl_adr      = adr_reg;
  // Derived from a register, so it is glitch-free and drops with busy.
  assign cpu_ready    = ~busy_reg;
  assign crtc_nCS     = ncs_reg;
  assign crtc_RnW     = rnw_reg;
  assign crtc_RS      = rs_reg;
  assign crtc_data    = data_reg;
  assign crtc_data_oe = oe_reg;
  assign crtc_nRESET  = nreset_reg;

endmodule

// File: tb/tb_crtc_mode_loader.sv
// Testbench for crtc_mode_loader: table-driven idle passthrough vectors plus
// hand-written load sequences (plain, en-toggled, disturbed, chained, reset
// abort). Prints one line per transaction and a final summary line.

module tb_crtc_mode_loader;

`ifdef CRTC_LOADER_CURSOR_PRESERVE_EN
  localparam int NWR = 14;
`else
  localparam int NWR = 16;
`endif
  localparam int DONE_CYC = 3 * NWR + 1;

  logic       clk = 1'b0;
  logic       RESET;
  logic       en;
  logic       start;
  logic [2:0] mode;
  logic       busy, done;
  logic [6:0] tbl_adr;
  logic [7:0] tbl_data;
  logic       cpu_nCS, cpu_RnW, cpu_RS;
  logic [7:0] cpu_data;
  logic       cpu_ready;
  logic       crtc_nCS, crtc_RnW, crtc_RS;
  logic [7:0] crtc_data;
  logic       crtc_data_oe, crtc_nRESET;

  int n_checks = 0;
  int n_pass   = 0;

  // Log of CRTC writes: {tbl_adr, RS, data}
  logic [15:0] wlog[$];

  always #5 clk = ~clk;

  crtc_mode_loader #(.NUM_REGS(16), .MODE_W(3)) dut (
    .clk(clk), .RESET(RESET), .en(en), .start(start), .mode(mode),
    .busy(busy), .done(done), .tbl_adr(tbl_adr), .tbl_data(tbl_data),
    .cpu_nCS(cpu_nCS), .cpu_RnW(cpu_RnW), .cpu_RS(cpu_RS), .cpu_data(cpu_data),
    .cpu_ready(cpu_ready), .crtc_nCS(crtc_nCS), .crtc_RnW(crtc_RnW),
    .crtc_RS(crtc_RS), .crtc_data(crtc_data), .crtc_data_oe(crtc_data_oe),
    .crtc_nRESET(crtc_nRESET)
  );

  // Mode table model: mode 3 holds 0x30+idx, other modes hold 0xFF-{mode,idx}.
  function automatic logic [7:0] tbl_fn(input logic [6:0] a);
    if (a[6:4] == 3'd3) return {1'b0, a};
    return 8'hFF - {1'b0, a};
  endfunction

  assign tbl_data = tbl_fn(tbl_adr);

  function automatic logic [22:0] outs();
    return {busy, done, cpu_ready, crtc_nCS, crtc_RnW, crtc_RS, crtc_data,
            crtc_data_oe, crtc_nRESET, tbl_adr};
  endfunction

  localparam logic [22:0] RST_EXP = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00,
                                     1'b0, 1'b0, 7'h00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    #1;
    if (e && !crtc_nCS && !crtc_RnW)
      wlog.push_back({tbl_adr, crtc_RS, crtc_data});
  endtask

  task automatic cpu_idle();
    cpu_nCS = 1'b1; cpu_RnW = 1'b1; cpu_RS = 1'b0; cpu_data = 8'h00;
  endtask

  // Accepts a load of mode m and runs it to the done pulse. Returns with the
  // sample taken just after the edge that raised done.
  task automatic do_load(input logic [2:0] m, input bit toggle, input bit disturb);
    int k;
    bit seen, busy_bad, nrst_bad, rdy_bad, frz_bad;
    logic [22:0] snap;
    logic [6:0] a;
    logic [15:0] e0, e1;
    k = 0; seen = 0; busy_bad = 0; nrst_bad = 0; rdy_bad = 0; frz_bad = 0;
    wlog.delete();
    start = 1'b1; mode = m;
    step(1'b1);
    start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_done_low", done, 0);
    chk("accept_nreset", crtc_nRESET, 0);
    chk("accept_ready", cpu_ready, 0);
    for (int c = 0; c < 400 && !seen; c++) begin
      if (toggle) begin
        snap = outs();
        step(1'b0);
        if (outs() !== snap) frz_bad = 1;
      end
      if (disturb && k == 9) begin
        start = 1'b1; mode = 3'd5;
        cpu_nCS = 1'b0; cpu_RnW = 1'b0; cpu_RS = 1'b1; cpu_data = 8'hAA;
      end
      if (disturb && k == 13) begin
        start = 1'b0; cpu_idle();
      end
      step(1'b1);
      k++;
      if (disturb && k == 12) chk("stall_ready", cpu_ready, 0);
      if (done) seen = 1;
      else begin
        if (!busy) busy_bad = 1;
        if (crtc_nRESET) nrst_bad = 1;
        if (cpu_ready) rdy_bad = 1;
      end
    end
    chk("done_seen", seen, 1);
    chk("done_cycle", k, DONE_CYC);
    chk("busy_span", busy_bad, 0);
    chk("nreset_span", nrst_bad, 0);
    chk("ready_span", rdy_bad, 0);
    if (toggle) chk("en0_freeze", frz_bad, 0);
    chk("done_busy_low", busy, 0);
    chk("done_nreset_high", crtc_nRESET, 1);
    chk("done_ready", cpu_ready, 1);
    chk("done_bus_idle", {crtc_nCS, crtc_data_oe}, 2'b10);
    chk("write_count", wlog.size(), 2 * NWR);
    for (int i = 0; i < NWR; i++) begin
      a  = {m, 4'(i)};
      e0 = {a, 1'b0, 4'h0, 4'(i)};
      e1 = {a, 1'b1, tbl_fn(a)};
      if (2 * i + 1 < wlog.size()) begin
        chk($sformatf("wr_adr_R%0d", i), wlog[2*i], e0);
        chk($sformatf("wr_dat_R%0d", i), wlog[2*i+1], e1);
      end
    end
    $display("load mode=%0d toggle=%0d disturb=%0d: done after %0d en-cycles, %0d writes",
             m, toggle, disturb, k, wlog.size());
  endtask

  typedef struct {
    logic       ncs, rnw, rs;
    logic [7:0] d;
    logic       e;
    logic [11:0] exp;  // {nCS, RnW, RS, data, oe}
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b1, {3'b001, 8'h55, 1'b1}};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h0C, 1'b1, {3'b000, 8'h0C, 1'b1}};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, {3'b011, 8'hA5, 1'b0}};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, {3'b101, 8'h3C, 1'b0}};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h77, 1'b0, {3'b101, 8'h3C, 1'b0}};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, {3'b110, 8'h00, 1'b0}};

    RESET = 1'b1; en = 1'b0; start = 1'b0; mode = 3'd0;
    cpu_idle();
    #2;
    chk("reset_outputs", outs(), RST_EXP);
    step(1'b1);
    chk("reset_held", outs(), RST_EXP);
    RESET = 1'b0;
    step(1'b1);
    chk("release_nreset", crtc_nRESET, 1);
    chk("release_ready", cpu_ready, 1);
    chk("release_busy", busy, 0);

    // Idle passthrough vectors
    for (int v = 0; v < 6; v++) begin
      cpu_nCS = vecs[v].ncs; cpu_RnW = vecs[v].rnw;
      cpu_RS = vecs[v].rs; cpu_data = vecs[v].d;
      step(vecs[v].e);
      chk($sformatf("pass_vec%0d", v),
          {crtc_nCS, crtc_RnW, crtc_RS, crtc_data, crtc_data_oe}, vecs[v].exp);
      chk($sformatf("pass_ready%0d", v), cpu_ready, 1);
      $display("vec %0d: nCS=%0b RnW=%0b RS=%0b data=%02h en=%0b -> crtc %03h",
               v, vecs[v].ncs, vecs[v].rnw, vecs[v].rs, vecs[v].d, vecs[v].e,
               {crtc_nCS, crtc_RnW, crtc_RS, crtc_data, crtc_data_oe});
    end
    cpu_idle();
    step(1'b1);

    // Plain load, then done must be a single pulse
    do_load(3'd3, 1'b0, 1'b0);
    step(1'b1);
    chk("done_single_pulse", done, 0);

    // en toggling, then a disturbed load accepted right after DONE
    do_load(3'd3, 1'b1, 1'b0);
    do_load(3'd3, 1'b0, 1'b1);
    step(1'b1);

    // Reset abort at en-cycle 20
    start = 1'b1; mode = 3'd3;
    step(1'b1);
    start = 1'b0;
    for (int k = 1; k <= 20; k++) step(1'b1);
    chk("pre_abort_busy", busy, 1);
    #2 RESET = 1'b1;
    #1;
    chk("abort_outputs", outs(), RST_EXP);
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      chk("abort_no_done", {done, busy}, 2'b00);
    end
    RESET = 1'b0;
    step(1'b1);
    chk("abort_release_nreset", crtc_nRESET, 1);
    $display("reset abort at en-cycle 20 released");
    do_load(3'd6, 1'b0, 1'b0);
    step(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
